// File: rtl/lsu_pkg.sv
// Address map, access-size encoding and byte-lane helpers shared by the
// MMIO load/store unit and its bus interface.
package lsu_pkg;

    localparam logic [31:0] ADDR_DMEM_BASE = 32'h0000_2000;
    localparam logic [31:0] ADDR_LEDR      = 32'h0000_7000;
    localparam logic [31:0] ADDR_LEDG      = 32'h0000_7010;
    localparam logic [31:0] ADDR_LCD       = 32'h0000_7030;
    localparam logic [31:0] ADDR_SW        = 32'h0000_7800;
    localparam logic [31:0] ADDR_BTN       = 32'h0000_7810;
    localparam logic [31:0] ADDR_BTN_EDGE  = 32'h0000_7814;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } lsu_size_e;

    function automatic logic [3:0] byte_en(input lsu_size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic access_bad(input lsu_size_e size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = |lane;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Right-aligned store data copied into every lane it could land in.
    function automatic logic [31:0] lane_data(input lsu_size_e size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage

// File: rtl/lsu_mmio_if.sv
// Load/store request, load response and peripheral pin bundle of the
// MMIO load/store unit.
interface lsu_mmio_if #(
    parameter int NUM_BTN  = 4,
    parameter int SW_WIDTH = 32
);
    logic [31:0]         addr;
    logic [31:0]         st_data;
    logic                wren;
    logic                rden;
    logic [1:0]          size;
    logic                ld_unsigned;
    logic [SW_WIDTH-1:0] sw;
    logic [NUM_BTN-1:0]  btn;
    logic [31:0]         ld_data;
    logic                ld_valid;
    logic                misaligned;
    logic [31:0]         ledr;
    logic [31:0]         ledg;
    logic [31:0]         lcd;

    modport master (
        output addr, st_data, wren, rden, size, ld_unsigned, sw, btn,
        input  ld_data, ld_valid, misaligned, ledr, ledg, lcd
    );

    modport slave (
        input  addr, st_data, wren, rden, size, ld_unsigned, sw, btn,
        output ld_data, ld_valid, misaligned, ledr, ledg, lcd
    );
endinterface

// File: rtl/lsu_mmio_io_sync_edge.sv
// Multi-flop synchroniser for asynchronous inputs with a one-cycle
// rising-edge pulse derived from the synchronised level.
module io_sync_edge #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise
);
    logic [WIDTH-1:0] chain [STAGES];
    logic [WIDTH-1:0] prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) chain[i] <= '0;
            prev <= '0;
        end else begin
            chain[0] <= din;
            for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
            prev <= chain[STAGES-1];
        end
    end

    assign dout = chain[STAGES-1];
    assign rise = dout & ~prev;
endmodule

// File: rtl/lsu_mmio.sv
// Load/store unit: byte/half/word access to on-chip data memory and to
// memory-mapped LED/LCD/switch/button registers, 1-cycle load latency.
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS  = 2048,
    parameter int NUM_BTN     = 4,
    parameter int SW_WIDTH    = 32,
    parameter int SYNC_STAGES = 2
) (
    input logic       clk,
    input logic       rst,
    lsu_mmio_if.slave bus
);
    localparam int AW = $clog2(DMEM_WORDS);

    lsu_size_e           size;
    logic [1:0]          lane;
    logic                mis;
    logic                wr_ok;
    logic                ld_req;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [31:0]         wmask;

    logic [29:0]         dmem_woff;
    logic [AW-1:0]       dmem_idx;
    logic                hit_dmem;
    logic                hit_ledr;
    logic                hit_ledg;
    logic                hit_lcd;
    logic                hit_sw;
    logic                hit_btn;
    logic                hit_edge;

    logic [SW_WIDTH-1:0] sw_lvl;
    logic [SW_WIDTH-1:0] sw_rise_unused;
    logic [NUM_BTN-1:0]  btn_lvl;
    logic [NUM_BTN-1:0]  btn_rise;
    logic [NUM_BTN-1:0]  btn_clr;
    logic [NUM_BTN-1:0]  btn_edge;

    logic [31:0]         ledr;
    logic [31:0]         ledg;
    logic [31:0]         lcd;
    logic [31:0]         io_word;

    logic [31:0]         dmem [DMEM_WORDS];

    logic [31:0]         dmem_rd_p0;
    logic [31:0]         io_rd_p0;
    logic                src_dmem_p0;
    logic [1:0]          lane_p0;
    lsu_size_e           size_p0;
    logic                uns_p0;
    logic                vld_p0;
    logic                mis_p0;
    logic [31:0]         raw_p0;

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lsel,
                                                input lsu_size_e sz, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lsel, 3'b000};
        case (sz)
            SZ_BYTE: res = {{24{~uns & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{~uns & sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign size   = lsu_size_e'(bus.size);
    assign lane   = bus.addr[1:0];
    assign mis    = (bus.wren | bus.rden) & access_bad(size, lane);
    assign wr_ok  = bus.wren & ~mis;
    assign ld_req = bus.rden & ~bus.wren;
    assign be     = byte_en(size, lane);
    assign wdata  = lane_data(size, bus.st_data);
    assign wmask  = lane_mask(be);

    assign dmem_woff = bus.addr[31:2] - ADDR_DMEM_BASE[31:2];
    assign dmem_idx  = dmem_woff[AW-1:0];
    assign hit_dmem  = (bus.addr[31:2] >= ADDR_DMEM_BASE[31:2]) && (dmem_woff < 30'(DMEM_WORDS));
    assign hit_ledr  = bus.addr[31:2] == ADDR_LEDR[31:2];
    assign hit_ledg  = bus.addr[31:2] == ADDR_LEDG[31:2];
    assign hit_lcd   = bus.addr[31:2] == ADDR_LCD[31:2];
    assign hit_sw    = bus.addr[31:2] == ADDR_SW[31:2];
    assign hit_btn   = bus.addr[31:2] == ADDR_BTN[31:2];
    assign hit_edge  = bus.addr[31:2] == ADDR_BTN_EDGE[31:2];

    io_sync_edge #(
        .WIDTH  (NUM_BTN),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.btn),
        .dout (btn_lvl),
        .rise (btn_rise)
    );

    io_sync_edge #(
        .WIDTH  (SW_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (bus.sw),
        .dout (sw_lvl),
        .rise (sw_rise_unused)
    );

    // W1C clear mask limited to the lanes actually written.
    always_comb begin
        btn_clr = '0;
        for (int i = 0; i < NUM_BTN; i++)
            btn_clr[i] = wr_ok & hit_edge & wdata[i] & wmask[i];
    end

    always_comb begin
        io_word = '0;
        if (hit_ledr) io_word = ledr;
        if (hit_ledg) io_word = ledg;
        if (hit_lcd)  io_word = lcd;
        if (hit_sw)   io_word[SW_WIDTH-1:0] = sw_lvl;
        if (hit_btn)  io_word[NUM_BTN-1:0]  = btn_lvl;
        if (hit_edge) io_word[NUM_BTN-1:0]  = btn_edge;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ledr     <= '0;
            ledg     <= '0;
            lcd      <= '0;
            btn_edge <= '0;
        end else begin
            if (wr_ok && hit_ledr) ledr <= (ledr & ~wmask) | (wdata & wmask);
            if (wr_ok && hit_ledg) ledg <= (ledg & ~wmask) | (wdata & wmask);
            if (wr_ok && hit_lcd)  lcd  <= (lcd  & ~wmask) | (wdata & wmask);
            // A fresh edge in the same cycle as its clear must not be lost.
            btn_edge <= (btn_edge & ~btn_clr) | btn_rise;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok && hit_dmem) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dmem[dmem_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // ---- stage p0: request captured, DMEM read registered ----
    always_ff @(posedge clk) begin
        if (ld_req && hit_dmem) dmem_rd_p0 <= dmem[dmem_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0      <= 1'b0;
            mis_p0      <= 1'b0;
            src_dmem_p0 <= 1'b0;
            io_rd_p0    <= '0;
            lane_p0     <= '0;
            size_p0     <= SZ_BYTE;
            uns_p0      <= 1'b0;
        end else begin
            vld_p0 <= ld_req;
            mis_p0 <= mis;
            if (ld_req) begin
                src_dmem_p0 <= hit_dmem & ~mis;
                io_rd_p0    <= mis ? '0 : io_word;
                lane_p0     <= lane;
                size_p0     <= size;
                uns_p0      <= bus.ld_unsigned;
            end
        end
    end

    assign raw_p0 = src_dmem_p0 ? dmem_rd_p0 : io_rd_p0;

    assign bus.ld_data    = extend_load(raw_p0, lane_p0, size_p0, uns_p0);
    assign bus.ld_valid   = vld_p0;
    assign bus.misaligned = mis_p0;
    assign bus.ledr       = ledr;
    assign bus.ledg       = ledg;
    assign bus.lcd        = lcd;

endmodule

// File: tb/tb_lsu_mmio.sv
// Bench for lsu_mmio: directed scenarios plus randomized traffic checked
// against a byte-addressed behavioural model of the memory map.
module tb_lsu_mmio;
    localparam int DMEM_WORDS = 2048;
    localparam int NUM_BTN    = 4;
    localparam int SW_WIDTH   = 32;
    localparam int STG        = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mmio_if #(.NUM_BTN(NUM_BTN), .SW_WIDTH(SW_WIDTH)) bus ();

    lsu_mmio #(
        .DMEM_WORDS  (DMEM_WORDS),
        .NUM_BTN     (NUM_BTN),
        .SW_WIDTH    (SW_WIDTH),
        .SYNC_STAGES (STG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [7:0]          dmem_m [logic [31:0]];
    logic [31:0]         ledr_m, ledg_m, lcd_m;
    logic [NUM_BTN-1:0]  edge_m;
    logic [NUM_BTN-1:0]  btn_q [$];
    logic [SW_WIDTH-1:0] sw_q  [$];
    logic [31:0]         exp_data;
    logic                exp_vld, exp_mis;

    task automatic model_reset();
        ledr_m = '0; ledg_m = '0; lcd_m = '0; edge_m = '0;
        exp_data = '0; exp_vld = 1'b0; exp_mis = 1'b0;
        btn_q.delete(); sw_q.delete();
        for (int i = 0; i <= STG; i++) begin
            btn_q.push_back('0);
            sw_q.push_back('0);
        end
    endtask

    function automatic logic in_dmem(input logic [31:0] a);
        return (a >= 32'h2000) && (a < 32'(32'h2000 + 4 * DMEM_WORDS));
    endfunction

    function automatic logic [7:0] map_rd_byte(input logic [31:0] a);
        logic [31:0] w;
        w = '0;
        if (in_dmem(a)) return dmem_m.exists(a) ? dmem_m[a] : 8'h00;
        case ({a[31:2], 2'b00})
            32'h7000: w = ledr_m;
            32'h7010: w = ledg_m;
            32'h7030: w = lcd_m;
            32'h7800: w = 32'(sw_q[STG-1]);
            32'h7810: w = 32'(btn_q[STG-1]);
            32'h7814: w = 32'(edge_m);
            default:  w = '0;
        endcase
        return w[8*a[1:0] +: 8];
    endfunction

    task automatic map_wr_byte(input logic [31:0] a, input logic [7:0] b);
        int l;
        l = int'(a[1:0]);
        if (in_dmem(a)) begin
            dmem_m[a] = b;
            return;
        end
        case ({a[31:2], 2'b00})
            32'h7000: ledr_m[8*l +: 8] = b;
            32'h7010: ledg_m[8*l +: 8] = b;
            32'h7030: lcd_m[8*l +: 8]  = b;
            32'h7814: for (int j = 0; j < 8; j++)
                          if (8*l + j < NUM_BTN && b[j]) edge_m[8*l + j] = 1'b0;
            default: ;
        endcase
    endtask

    task automatic model_step(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d, input logic [1:0] sz, input logic uns);
        int n;
        logic bad;
        logic [NUM_BTN-1:0] rise;
        logic [31:0] v;
        n    = 1 << sz;
        bad  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        rise = btn_q[STG-1] & ~btn_q[STG];
        exp_mis = (wr | rd) & bad;
        exp_vld = rd & ~wr;
        if (exp_vld) begin
            v = '0;
            if (!bad) begin
                for (int i = 0; i < n; i++)
                    v |= 32'(map_rd_byte(a + 32'(i))) << (8*i);
                if (!uns && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8*n);
            end
            exp_data = v;
        end
        if (wr && !bad)
            for (int i = 0; i < n; i++) map_wr_byte(a + 32'(i), d[8*i +: 8]);
        edge_m |= rise;
        btn_q.push_front(bus.btn); void'(btn_q.pop_back());
        sw_q.push_front(bus.sw);   void'(sw_q.pop_back());
    endtask

    task automatic do_cycle(input logic wr, input logic rd, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] sz, input logic uns);
        bus.wren = wr; bus.rden = rd; bus.addr = a; bus.st_data = d;
        bus.size = sz; bus.ld_unsigned = uns;
        @(posedge clk);
        model_step(wr, rd, a, d, sz, uns);
        @(negedge clk);
        bus.wren = 1'b0; bus.rden = 1'b0;
        chk("ld_valid",   32'(bus.ld_valid),   32'(exp_vld));
        chk("misaligned", 32'(bus.misaligned), 32'(exp_mis));
        chk("ld_data",    bus.ld_data,         exp_data);
        chk("ledr",       bus.ledr,            ledr_m);
        chk("ledg",       bus.ledg,            ledg_m);
        chk("lcd",        bus.lcd,             lcd_m);
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        do_cycle(1'b1, 1'b0, a, d, sz, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        do_cycle(1'b0, 1'b1, a, 32'h0, sz, uns);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.addr = '0; bus.st_data = '0; bus.wren = 1'b0; bus.rden = 1'b0;
        bus.size = '0; bus.ld_unsigned = 1'b0; bus.sw = '0; bus.btn = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ld_data",  bus.ld_data,           32'h0);
        chk("rst_ld_valid", 32'(bus.ld_valid),     32'h0);
        chk("rst_mis",      32'(bus.misaligned),   32'h0);
        chk("rst_ledr",     bus.ledr,              32'h0);
        chk("rst_ledg",     bus.ledg,              32'h0);
        chk("rst_lcd",      bus.lcd,               32'h0);
        rst = 1'b0;

        for (int w = 0; w < 16; w++) st(32'h2000 + 32'(4*w), 32'h0, 2'd2);

        // DMEM sub-word access and extension
        st(32'h2004, 32'h80FF_7F01, 2'd2);
        ld(32'h2007, 2'd0, 1'b1); chk("lbu_2007", bus.ld_data, 32'h0000_0080);
        ld(32'h2007, 2'd0, 1'b0); chk("lb_2007",  bus.ld_data, 32'hFFFF_FF80);
        ld(32'h2006, 2'd1, 1'b0); chk("lh_2006",  bus.ld_data, 32'hFFFF_80FF);
        idle(1);                  chk("vld_drop", 32'(bus.ld_valid), 32'h0);

        // DMEM top boundary and first unmapped word above it
        st(32'h3FFC, 32'hCAFE_F00D, 2'd2);
        ld(32'h3FFC, 2'd2, 1'b0); chk("dmem_top",   bus.ld_data, 32'hCAFE_F00D);
        ld(32'h4000, 2'd2, 1'b0); chk("above_dmem", bus.ld_data, 32'h0);

        st(32'h7010, 32'h0, 2'd2);
        st(32'h7012, 32'hAB, 2'd0); chk("ledg_lane2", bus.ledg, 32'h00AB_0000);

        // Alignment violations
        st(32'h2002, 32'h1234_5678, 2'd2); chk("mis_st", 32'(bus.misaligned), 32'h1);
        idle(1);                           chk("mis_once", 32'(bus.misaligned), 32'h0);
        ld(32'h2000, 2'd2, 1'b0);          chk("mis_st_w0", bus.ld_data, 32'h0);
        ld(32'h2004, 2'd2, 1'b0);          chk("mis_st_w1", bus.ld_data, 32'h80FF_7F01);
        ld(32'h7011, 2'd1, 1'b0);
        chk("mis_ld_data", bus.ld_data, 32'h0);
        chk("mis_ld_vld",  32'(bus.ld_valid), 32'h1);
        chk("mis_ld_flag", 32'(bus.misaligned), 32'h1);

        // Button synchronisation, edge capture and W1C
        bus.btn = 4'b0100;
        idle(STG + 1);
        ld(32'h7810, 2'd2, 1'b1); chk("btn_lvl",  bus.ld_data, 32'h4);
        ld(32'h7814, 2'd2, 1'b1); chk("btn_edge", bus.ld_data, 32'h4);
        ld(32'h7814, 2'd2, 1'b1); chk("edge_nd",  bus.ld_data, 32'h4);
        st(32'h7814, 32'h4, 2'd2);
        ld(32'h7814, 2'd2, 1'b1); chk("edge_clr", bus.ld_data, 32'h0);
        bus.btn = 4'b0000;
        idle(STG + 2);
        bus.btn = 4'b0100;
        idle(STG + 1);
        ld(32'h7814, 2'd2, 1'b1); chk("edge_again", bus.ld_data, 32'h4);

        // Clear and new edge of button 0 in the same cycle
        bus.btn = 4'b0001;
        idle(STG + 1);
        bus.btn = 4'b0000;
        idle(STG + 2);
        bus.btn = 4'b0001;
        idle(STG);
        st(32'h7814, 32'h1, 2'd2);
        ld(32'h7814, 2'd2, 1'b1); chk("set_wins", bus.ld_data & 32'h1, 32'h1);

        do_cycle(1'b1, 1'b1, 32'h7000, 32'h1234_5678, 2'd2, 1'b0);
        chk("both_vld",  32'(bus.ld_valid), 32'h0);
        chk("both_ledr", bus.ledr, 32'h1234_5678);

        // Asynchronous reset in the middle of a cycle
        st(32'h7000, 32'hDEAD_BEEF, 2'd2);
        ld(32'h7000, 2'd2, 1'b0); chk("ld_after_st", bus.ld_data, 32'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ledr",    bus.ledr,          32'h0);
        chk("arst_ld_data", bus.ld_data,       32'h0);
        chk("arst_ld_vld",  32'(bus.ld_valid), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        ld(32'h7814, 2'd2, 1'b1); chk("arst_edge", bus.ld_data, 32'h0);
        ld(32'h2004, 2'd2, 1'b0); chk("dmem_kept", bus.ld_data, 32'h80FF_7F01);

        // Randomized traffic over the whole map
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [1:0]  sz;
            logic        wr, rd, uns;
            int          r, k;
            if ($urandom_range(0, 9) == 0) bus.btn = NUM_BTN'($urandom);
            if ($urandom_range(0, 19) == 0) bus.sw = SW_WIDTH'($urandom);
            r = int'($urandom_range(0, 9));
            case (r)
                0, 1, 2, 3, 4: a = 32'h2000 + 32'($urandom_range(0, 63));
                5: a = 32'h7000 + 32'($urandom_range(0, 3));
                6: a = 32'h7010 + 32'($urandom_range(0, 3));
                7: a = 32'h7030 + 32'($urandom_range(0, 3));
                8: begin
                    k = int'($urandom_range(0, 2));
                    a = (k == 0) ? 32'h7800 : (k == 1) ? 32'h7810 : 32'h7814;
                    a = a + 32'($urandom_range(0, 3));
                end
                default: begin
                    k = int'($urandom_range(0, 3));
                    case (k)
                        0: a = 32'h7004;
                        1: a = 32'h4000 + 32'($urandom_range(0, 3));
                        2: a = 32'h1FFC + 32'($urandom_range(0, 3));
                        default: a = $urandom | 32'h8000_0000;
                    endcase
                end
            endcase
            d   = $urandom;
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            wr  = (k >= 4 && k <= 8);
            rd  = (k < 4 || k == 8);
            do_cycle(wr, rd, a, d, sz, uns);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
